// File: rtl/button_event.sv
// Button event generator: turns a debounced button level into press, release,
// long-press and auto-repeat pulses, plus held/long-hold levels and a press counter.
module button_event #(
    parameter int LONG_CYCLES   = 1000,
    parameter int REPEAT_CYCLES = 250,
    parameter int CNT_W         = 10
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic       long_active,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PRESS  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_pulse_q, press_pulse_d;
    logic             release_pulse_q, release_pulse_d;
    logic             long_pulse_q, long_pulse_d;
    logic             repeat_pulse_q, repeat_pulse_d;
    logic [7:0]       press_count_q, press_count_d;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
        state_d         = state_q;
        cnt_d           = cnt_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        repeat_pulse_d  = 1'b0;
        press_count_d   = press_count_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (btn_level) begin
                    state_d       = PRESS;
                    press_pulse_d = 1'b1;
                    press_count_d = press_count_q + 8'd1;
                end
            end
            PRESS: begin
                // Release is tested first so it wins over a long-press on the same edge.
                if (!btn_level) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d      = REPEAT;
                    cnt_d        = '0;
                    long_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPEAT: begin
                if (!btn_level) begin
                    state_d         = IDLE;
                    cnt_d           = '0;
                    release_pulse_d = 1'b1;
                end else if (cnt_q == REPEAT_LAST) begin
                    cnt_d          = '0;
                    repeat_pulse_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            repeat_pulse_q  <= 1'b0;
            press_count_q   <= 8'd0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            repeat_pulse_q  <= repeat_pulse_d;
            press_count_q   <= press_count_d;
        end
    end

    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign repeat_pulse  = repeat_pulse_q;
    assign press_count   = press_count_q;
    assign held          = (state_q == PRESS) || (state_q == REPEAT);
    assign long_active   = (state_q == REPEAT);

endmodule

// File: tb/tb_button_event.sv
// Directed testbench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=4.
module tb_button_event;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       btn_level = 1'b0;
    logic       press_pulse, release_pulse, long_pulse, repeat_pulse;
    logic       held, long_active;
    logic [7:0] press_count;

    int passed = 0;
    int total  = 0;
    logic [7:0] exp_count = 8'd0;

    button_event #(
        .LONG_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .CNT_W        (4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .btn_level    (btn_level),
        .press_pulse  (press_pulse),
        .release_pulse(release_pulse),
        .long_pulse   (long_pulse),
        .repeat_pulse (repeat_pulse),
        .held         (held),
        .long_active  (long_active),
        .press_count  (press_count)
    );

    always #5 clock = ~clock;

    // Pulses packed as {press, release, long, repeat}.
    function automatic logic [3:0] pulses();
        return {press_pulse, release_pulse, long_pulse, repeat_pulse};
    endfunction

    // One rising edge, then settle on the falling edge where inputs change and outputs are sampled.
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        btn_level = 1'b0;
        step();
        step();
        total++;
        if ({pulses(), held, long_active, press_count} !== 14'd0)
            $display("FAIL reset_state: got pulses=%b held=%b long=%b count=%0d, want all 0",
                     pulses(), held, long_active, press_count);
        else passed++;
        reset_n = 1'b1;
        step();
        total++;
        if ({pulses(), held} !== 5'd0)
            $display("FAIL reset_idle: got pulses=%b held=%b, want 0000/0", pulses(), held);
        else passed++;
        exp_count = 8'd0;
    endtask

    task automatic test_short_press();
        logic [3:0] exp_p [4] = '{4'b1000, 4'b0000, 4'b0000, 4'b0100};
        logic       exp_h [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            btn_level = (i < 3);
            step();
            total++;
            if (pulses() !== exp_p[i] || held !== exp_h[i])
                $display("FAIL short_press cycle %0d: got pulses=%b held=%b, want %b/%b",
                         i + 1, pulses(), held, exp_p[i], exp_h[i]);
            else passed++;
        end
        exp_count++;
        total++;
        if (press_count !== exp_count)
            $display("FAIL short_press_count: got %0d want %0d", press_count, exp_count);
        else passed++;
    endtask

    task automatic test_long_hold();
        logic [3:0] exp_p;
        btn_level = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            step();
            if (i == 0) exp_p = 4'b1000;
            else if (i == 8) exp_p = 4'b0010;
            else if (i == 12 || i == 16 || i == 20) exp_p = 4'b0001;
            else exp_p = 4'b0000;
            total++;
            if (pulses() !== exp_p || held !== 1'b1 || long_active !== (i >= 8))
                $display("FAIL long_hold t+%0d: got pulses=%b held=%b long_active=%b, want %b/1/%b",
                         i, pulses(), held, long_active, exp_p, (i >= 8));
            else passed++;
        end
        btn_level = 1'b0;
        step();
        exp_count++;
        total++;
        if (pulses() !== 4'b0100 || held !== 1'b0 || long_active !== 1'b0 || press_count !== exp_count)
            $display("FAIL long_hold_release: got pulses=%b held=%b long_active=%b count=%0d, want 0100/0/0/%0d",
                     pulses(), held, long_active, press_count, exp_count);
        else passed++;
    endtask

    task automatic test_long_boundary();
        btn_level = 1'b1;
        step();
        exp_count++;
        total++;
        if (pulses() !== 4'b1000)
            $display("FAIL boundary_press: got pulses=%b want 1000", pulses());
        else passed++;
        for (int i = 1; i <= 7; i++) step();
        total++;
        if (pulses() !== 4'b0000 || long_active !== 1'b0)
            $display("FAIL boundary_pre: got pulses=%b long_active=%b, want 0000/0", pulses(), long_active);
        else passed++;
        btn_level = 1'b0;
        step();
        total++;
        if (pulses() !== 4'b0100 || held !== 1'b0 || long_active !== 1'b0)
            $display("FAIL boundary_release: got pulses=%b held=%b long_active=%b, want 0100/0/0",
                     pulses(), held, long_active);
        else passed++;
        step();
        total++;
        if (pulses() !== 4'b0000 || held !== 1'b0)
            $display("FAIL boundary_idle: got pulses=%b held=%b, want 0000/0", pulses(), held);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic       lvl   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [3:0] exp_p [5] = '{4'b1000, 4'b0100, 4'b1000, 4'b0100, 4'b0000};
        logic [7:0] start = exp_count;
        for (int i = 0; i < 5; i++) begin
            btn_level = lvl[i];
            step();
            total++;
            if (pulses() !== exp_p[i])
                $display("FAIL back_to_back cycle %0d: got pulses=%b want %b", i, pulses(), exp_p[i]);
            else passed++;
        end
        exp_count = start + 8'd2;
        total++;
        if (press_count !== exp_count)
            $display("FAIL back_to_back_count: got %0d want %0d", press_count, exp_count);
        else passed++;
    endtask

    task automatic test_wrap();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        exp_count = 8'd0;
        for (int n = 1; n <= 257; n++) begin
            btn_level = 1'b1;
            step();
            btn_level = 1'b0;
            step();
            if (n == 255 || n == 256) begin
                total++;
                if (press_count !== ((n == 255) ? 8'd255 : 8'd0))
                    $display("FAIL wrap_at_%0d: got %0d want %0d", n, press_count, (n == 255) ? 255 : 0);
                else passed++;
            end
        end
        exp_count = 8'd1;
        total++;
        if (press_count !== exp_count)
            $display("FAIL wrap_257: got %0d want %0d", press_count, exp_count);
        else passed++;
    endtask

    task automatic test_reset_mid_hold();
        btn_level = 1'b1;
        for (int i = 0; i <= 10; i++) step();
        total++;
        if (long_active !== 1'b1 || held !== 1'b1)
            $display("FAIL midhold_in_repeat: got held=%b long_active=%b, want 1/1", held, long_active);
        else passed++;
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({pulses(), held, long_active, press_count} !== 14'd0)
            $display("FAIL midhold_async_reset: got pulses=%b held=%b long=%b count=%0d, want all 0",
                     pulses(), held, long_active, press_count);
        else passed++;
        step();
        total++;
        if ({pulses(), held, long_active} !== 6'd0)
            $display("FAIL midhold_no_release: got pulses=%b held=%b long=%b, want all 0",
                     pulses(), held, long_active);
        else passed++;
        reset_n = 1'b1;
        step();
        total++;
        if (pulses() !== 4'b1000 || held !== 1'b1 || press_count !== 8'd1)
            $display("FAIL midhold_repress: got pulses=%b held=%b count=%0d, want 1000/1/1",
                     pulses(), held, press_count);
        else passed++;
        btn_level = 1'b0;
        step();
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_short_press();
        test_long_hold();
        test_long_boundary();
        test_back_to_back();
        test_wrap();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
